hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage core. It sequences the EX stage and produces:
- the registered forwarding selects `rs1_fwd_ex` and `rs2_fwd_ex` consumed by EX;
- stall, flush and bubble controls for the IF/ID, ID/EX and EX/MEM pipeline registers.

It detects load-use hazards and arbitrates EX occupancy for multi-cycle MDU operations with a counter-driven FSM.

---
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, MDU EX occupancy FSM, branch flush, registered forward selects.
// Optional performance counters enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int MDU_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        rs1_used_id,
    input  logic        rs2_used_id,
    input  logic [4:0]  rd_ex,
    input  logic [4:0]  rd_mem,
    input  logic        reg_write_ex,
    input  logic        reg_write_mem,
    input  logic        mem_read_ex,
    input  logic        mdu_op_ex,
    input  logic        branch_taken_ex,
    output logic [1:0]  rs1_fwd_ex,
    output logic [1:0]  rs2_fwd_ex,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        bubble_mem,
    output logic        mdu_done,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    typedef enum logic [1:0] {IDLE, LDSTALL, MDU_BUSY, MDU_DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               ex_wr_ok, mem_wr_ok, load_use;
    logic [1:0]         fwd1_nxt, fwd2_nxt;

    assign ex_wr_ok  = reg_write_ex & (rd_ex != 5'd0);
    assign mem_wr_ok = reg_write_mem & (rd_mem != 5'd0);
    assign load_use  = mem_read_ex & ex_wr_ok &
                       ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));

    // EX match checked first so the youngest producer wins
    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                           input logic [4:0] rde, input logic ex_ok,
                                           input logic [4:0] rdm, input logic mem_ok);
        if (used && ex_ok && rs == rde)
            return 2'b01;
        else if (used && mem_ok && rs == rdm)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign fwd1_nxt = fwd_sel(rs1_used_id, rs1_id, rd_ex, ex_wr_ok, rd_mem, mem_wr_ok);
    assign fwd2_nxt = fwd_sel(rs2_used_id, rs2_id, rd_ex, ex_wr_ok, rd_mem, mem_wr_ok);

    // Controls act in the same cycle as the triggering inputs; reset forces them low at once
    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        bubble_mem = 1'b0;
        mdu_done   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (branch_taken_ex) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (mdu_op_ex) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                MDU_BUSY: begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_ex   = 1'b1;
                    bubble_mem = 1'b1;
                end
                MDU_DONE: mdu_done = 1'b1;
                default: ;
            endcase
        end
    end

    // Entry cycle + MDU_LATENCY-2 busy cycles + DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!branch_taken_ex && mdu_op_ex) begin
                        cnt   <= CNT_W'(MDU_LATENCY - 2);
                        state <= (MDU_LATENCY == 2) ? MDU_DONE : MDU_BUSY;
                    end else if (!branch_taken_ex && load_use) begin
                        state <= LDSTALL;
                    end
                end
                LDSTALL: state <= IDLE;
                MDU_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= MDU_DONE;
                end
                MDU_DONE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_fwd_ex <= 2'b00;
            rs2_fwd_ex <= 2'b00;
        end else if (flush_ex) begin
            rs1_fwd_ex <= 2'b00;
            rs2_fwd_ex <= 2'b00;
        end else if (!stall_ex) begin
            rs1_fwd_ex <= fwd1_nxt;
            rs2_fwd_ex <= fwd2_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_if) stall_cnt <= stall_cnt + 32'd1;
            if (flush_id) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDU_LATENCY=4): vector table for single-cycle cases, hand sequences for multi-cycle ones.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_id, rs2_id, rd_ex, rd_mem;
    logic        rs1_used_id, rs2_used_id, reg_write_ex, reg_write_mem;
    logic        mem_read_ex, mdu_op_ex, branch_taken_ex;
    logic [1:0]  rs1_fwd_ex, rs2_fwd_ex;
    logic        stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem, mdu_done;
    logic [31:0] stall_cnt, flush_cnt;
    logic [6:0]  ctl;
    logic [3:0]  fwd;
    int          pass_cnt = 0;
    int          total    = 0;

    hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_ex(rd_ex), .rd_mem(rd_mem),
        .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem),
        .mem_read_ex(mem_read_ex), .mdu_op_ex(mdu_op_ex), .branch_taken_ex(branch_taken_ex),
        .rs1_fwd_ex(rs1_fwd_ex), .rs2_fwd_ex(rs2_fwd_ex),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex), .bubble_mem(bubble_mem), .mdu_done(mdu_done),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem, mdu_done}
    assign ctl = {stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem, mdu_done};
    assign fwd = {rs1_fwd_ex, rs2_fwd_ex};

    localparam logic [6:0] C_NONE  = 7'b000_0000;
    localparam logic [6:0] C_LDUSE = 7'b110_0100;
    localparam logic [6:0] C_MDU   = 7'b111_0010;
    localparam logic [6:0] C_FLUSH = 7'b000_1100;
    localparam logic [6:0] C_DONE  = 7'b000_0001;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rde, rdm;
        logic       we_ex, we_mem, ld, br;
        logic [6:0] ctl_exp;
        logic [3:0] fwd_exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                         input logic [4:0] rde, input logic [4:0] rdm, input logic we_e,
                         input logic we_m, input logic ld, input logic mdu, input logic br);
        rs1_id = r1; rs2_id = r2; rs1_used_id = u1; rs2_used_id = u2;
        rd_ex = rde; rd_mem = rdm; reg_write_ex = we_e; reg_write_mem = we_m;
        mem_read_ex = ld; mdu_op_ex = mdu; branch_taken_ex = br;
    endtask

    // Called at a negedge with inputs already applied; ends at the next negedge
    task automatic cycle_chk(input string nm, input logic [6:0] ce, input logic [3:0] fe);
        #2;
        check({nm, "_ctl"}, {25'd0, ctl}, {25'd0, ce});
        @(posedge clk);
        #1;
        check({nm, "_fwd"}, {28'd0, fwd}, {28'd0, fe});
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] sc0;
        vecs[0] = '{"alu_ex_rs2",  0, 3, 0, 1, 3, 0, 1, 0, 0, 0, C_NONE,  4'b0001};
        vecs[1] = '{"alu_mem_rs2", 0, 3, 0, 1, 7, 3, 1, 1, 0, 0, C_NONE,  4'b0010};
        vecs[2] = '{"both_match",  0, 3, 0, 1, 3, 3, 1, 1, 0, 0, C_NONE,  4'b0001};
        vecs[3] = '{"x0_ex_load",  0, 0, 1, 0, 0, 0, 1, 0, 1, 0, C_NONE,  4'b0000};
        vecs[4] = '{"unused_src",  5, 0, 0, 0, 5, 0, 1, 0, 1, 0, C_NONE,  4'b0000};
        vecs[5] = '{"we_ex_off",   4, 0, 1, 0, 4, 4, 0, 1, 0, 0, C_NONE,  4'b1000};
        vecs[6] = '{"both_srcs",   6, 9, 1, 1, 6, 9, 1, 1, 0, 0, C_NONE,  4'b0110};
        vecs[7] = '{"branch_ld",   5, 0, 1, 0, 5, 0, 1, 0, 1, 1, C_FLUSH, 4'b0000};
        vecs[8] = '{"x0_mem",      0, 0, 1, 0, 2, 0, 0, 1, 0, 0, C_NONE,  4'b0000};

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        check("reset_ctl", {25'd0, ctl}, 32'd0);
        check("reset_fwd", {28'd0, fwd}, 32'd0);
        check("reset_cnt", stall_cnt | flush_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rde, vecs[i].rdm,
                  vecs[i].we_ex, vecs[i].we_mem, vecs[i].ld, 1'b0, vecs[i].br);
            cycle_chk(vecs[i].name, vecs[i].ctl_exp, vecs[i].fwd_exp);
        end

        // load-use: lw x5 in EX, ID reads x5; one stall then forward from WB
        drive(5, 0, 1, 0, 5, 0, 1, 0, 1, 0, 0);
        cycle_chk("lduse_stall", C_LDUSE, 4'b0000);
        drive(5, 0, 1, 0, 0, 5, 0, 1, 0, 0, 0);
        cycle_chk("lduse_release", C_NONE, 4'b1000);
        drive(0, 3, 0, 1, 3, 0, 1, 0, 0, 0, 0);
        cycle_chk("lduse_idle", C_NONE, 4'b0001);

        // MDU, latency 4: 3 stall cycles, DONE on 4th, branch ignored while busy
        sc0 = stall_cnt;
        drive(0, 0, 0, 0, 3, 0, 1, 0, 0, 1, 0);
        cycle_chk("mdu_entry", C_MDU, 4'b0001);
        drive(0, 0, 0, 0, 3, 0, 1, 0, 0, 1, 1);
        cycle_chk("mdu_busy1", C_MDU, 4'b0001);
        cycle_chk("mdu_busy2", C_MDU, 4'b0001);
        drive(3, 0, 1, 0, 3, 0, 1, 0, 0, 1, 0);
        cycle_chk("mdu_done", C_DONE, 4'b0100);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle_chk("mdu_after", C_NONE, 4'b0000);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_mdu", stall_cnt - sc0, 32'd3);
        check("perf_flush", flush_cnt, 32'd1);
`else
        check("perf_off", stall_cnt | flush_cnt | sc0, 32'd0);
`endif

        // async reset mid MDU_BUSY
        drive(0, 3, 0, 1, 3, 0, 1, 0, 0, 0, 0);
        cycle_chk("pre_rst_fwd", C_NONE, 4'b0001);
        drive(0, 3, 0, 1, 3, 0, 1, 0, 0, 1, 0);
        cycle_chk("rst_entry", C_MDU, 4'b0001);
        #2;
        check("rst_busy_ctl", {25'd0, ctl}, {25'd0, C_MDU});
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_ctl", {25'd0, ctl}, 32'd0);
        check("rst_async_fwd", {28'd0, fwd}, 32'd0);
        check("rst_async_cnt", stall_cnt | flush_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle_chk("rst_idle", C_NONE, 4'b0000);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
